// File: rtl/ex_pkg.sv
// Shared constants for the EX-stage ALU control decoder and the HI/LO
// multiply/divide unit: ALUOp encodings, funct codes, ALU control codes and
// the muldiv FSM state type.
package ex_pkg;

  // ALUOp values produced by the control unit
  localparam logic [3:0] ALU_OP_LOAD_STORE = 4'b0000;
  localparam logic [3:0] ALU_OP_BRANCH     = 4'b0001;
  localparam logic [3:0] ALU_OP_R_TYPE     = 4'b0010;
  localparam logic [3:0] ALU_OP_ANDI       = 4'b0100;
  localparam logic [3:0] ALU_OP_ORI        = 4'b0101;
  localparam logic [3:0] ALU_OP_SUB        = 4'b0111;
  localparam logic [3:0] ALU_OP_XORI       = 4'b1000;
  localparam logic [3:0] ALU_OP_LUI        = 4'b1001;
  localparam logic [3:0] ALU_OP_SLTI       = 4'b1100;

  // R-type funct codes handled by the HI/LO unit
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // ALU control codes driven to the ALU
  localparam logic [5:0] CODE_ADD = 6'b100000;
  localparam logic [5:0] CODE_SUB = 6'b100010;
  localparam logic [5:0] CODE_AND = 6'b100100;
  localparam logic [5:0] CODE_OR  = 6'b100101;
  localparam logic [5:0] CODE_XOR = 6'b100110;
  localparam logic [5:0] CODE_LUI = 6'b001111;
  localparam logic [5:0] CODE_SLT = 6'b101010;

  // Muldiv sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Radix-2 multiply/divide datapath. Holds operand magnitudes, the shifting
// accumulator/remainder and quotient/multiplier register, and produces the
// sign-corrected HI/LO results. Sequencing comes from ex_alu_muldiv_ctrl.
// MULDIV_SINGLE_CYCLE_MUL_EN: multiply loads the full product on start.
module ex_muldiv_datapath
  import ex_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               op_div_i,
  input  logic               op_signed_i,
  input  logic [NB_DATA-1:0] rs_i,
  input  logic [NB_DATA-1:0] rt_i,
  output logic [NB_DATA-1:0] res_hi_o,
  output logic [NB_DATA-1:0] res_lo_o
);

  // acc: upper product half / partial remainder; lo: multiplier bits / quotient
  logic [NB_DATA-1:0] acc_q, acc_d;
  logic [NB_DATA-1:0] lo_q, lo_d;
  logic [NB_DATA-1:0] opb_q, opb_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;

  logic               rs_neg, rt_neg;
  logic [NB_DATA-1:0] rs_mag, rt_mag;
  logic [NB_DATA:0]   mul_sum;
  logic [NB_DATA:0]   div_shift;
  logic               div_ge;
  logic [NB_DATA-1:0] div_diff;
  logic [2*NB_DATA-1:0] prod_fix;
  logic [NB_DATA-1:0] quo_fix, rem_fix;

  assign rs_neg = op_signed_i & rs_i[NB_DATA-1];
  assign rt_neg = op_signed_i & rt_i[NB_DATA-1];
  assign rs_mag = rs_neg ? (-rs_i) : rs_i;
  assign rt_mag = rt_neg ? (-rt_i) : rt_i;

  // Multiply step adds the multiplicand when the current multiplier bit is set
  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  // Restoring divide step: shift next dividend bit in, trial-subtract divisor.
  // When the trial succeeds the difference is below the divisor, so NB_DATA
  // bits of modular subtraction are exact.
  assign div_shift = {acc_q, lo_q[NB_DATA-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift[NB_DATA-1:0] - opb_q;

  // Next-state for the operand/accumulator registers
  always_comb begin
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    div_d     = div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    if (load_i) begin
      acc_d     = '0;
      div_d     = op_div_i;
      neg_d     = rs_neg ^ rt_neg;
      neg_rem_d = rs_neg;
      div0_d    = op_div_i && (rt_i == '0);
      if (op_div_i) begin
        lo_d  = rs_mag;
        opb_d = rt_mag;
      end else begin
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
        {acc_d, lo_d} = {{NB_DATA{1'b0}}, rs_mag} * {{NB_DATA{1'b0}}, rt_mag};
        opb_d         = rs_mag;
`else
        lo_d  = rt_mag;
        opb_d = rs_mag;
`endif
      end
    end else if (step_i) begin
      if (div_q) begin
        acc_d = div_ge ? div_diff : div_shift[NB_DATA-1:0];
        lo_d  = {lo_q[NB_DATA-2:0], div_ge};
      end else begin
        acc_d = mul_sum[NB_DATA:1];
        lo_d  = {mul_sum[0], lo_q[NB_DATA-1:1]};
      end
    end
  end

  // Operand/accumulator registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  // Sign fix-up of the magnitude result; divide by zero forces an all-ones
  // quotient while the remainder naturally equals the dividend.
  always_comb begin
    prod_fix = {acc_q, lo_q};
    if (neg_q) prod_fix = -{acc_q, lo_q};
    quo_fix = neg_q ? (-lo_q) : lo_q;
    if (div0_q) quo_fix = '1;
    rem_fix = neg_rem_q ? (-acc_q) : acc_q;
    if (div_q) begin
      res_hi_o = rem_fix;
      res_lo_o = quo_fix;
    end else begin
      res_hi_o = prod_fix[2*NB_DATA-1:NB_DATA];
      res_lo_o = prod_fix[NB_DATA-1:0];
    end
  end

endmodule

// File: rtl/ex_alu_muldiv_ctrl.sv
// EX-stage ALU control decoder plus HI/LO multiply/divide sequencer.
// Decode maps ALUOp/funct to the ALU control code combinationally. The
// sequencer runs MULT/MULTU/DIV/DIVU over NB_DATA cycles, stalling the
// pipeline, and handles MTHI/MTLO writes and flush aborts.
// Optional build macro MULDIV_SINGLE_CYCLE_MUL_EN: multiplies finish in
// two cycles (start -> DONE) with a one-cycle stall.
// Handshake: o_stall is high while the EX instruction must be held; an
// instruction in EX leaves it at the first rising edge where o_stall is low.
module ex_alu_muldiv_ctrl
  import ex_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_FUNCT  = 6,
  parameter int NB_ALU_OP = 4,
  parameter int NB_CNT    = $clog2(NB_DATA) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [NB_ALU_OP-1:0] i_alu_op_CU,
  input  logic [NB_FUNCT-1:0]  i_op_r_tipe,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  output logic [NB_FUNCT-1:0]  o_alu_control_signals,
  output logic                 o_stall,
  output logic                 o_busy,
  output logic [NB_DATA-1:0]   o_hi,
  output logic [NB_DATA-1:0]   o_lo
);

  muldiv_state_e      state_q;
  logic [NB_CNT-1:0]  cnt_q;
  logic [NB_DATA-1:0] hi_q, lo_q;
  logic               busy_q;

  logic               is_rtype, is_mul, is_div, op_signed;
  logic               start, mthi_we, mtlo_we, step;
  logic [NB_DATA-1:0] res_hi, res_lo;

  // ALUOp/funct to ALU control code
  always_comb begin
    o_alu_control_signals = NB_FUNCT'(CODE_ADD);
    case (i_alu_op_CU)
      NB_ALU_OP'(ALU_OP_R_TYPE):     o_alu_control_signals = i_op_r_tipe;
      NB_ALU_OP'(ALU_OP_LOAD_STORE): o_alu_control_signals = NB_FUNCT'(CODE_ADD);
      NB_ALU_OP'(ALU_OP_BRANCH):     o_alu_control_signals = NB_FUNCT'(CODE_ADD);
      NB_ALU_OP'(ALU_OP_ANDI):       o_alu_control_signals = NB_FUNCT'(CODE_AND);
      NB_ALU_OP'(ALU_OP_ORI):        o_alu_control_signals = NB_FUNCT'(CODE_OR);
      NB_ALU_OP'(ALU_OP_XORI):       o_alu_control_signals = NB_FUNCT'(CODE_XOR);
      NB_ALU_OP'(ALU_OP_LUI):        o_alu_control_signals = NB_FUNCT'(CODE_LUI);
      NB_ALU_OP'(ALU_OP_SLTI):       o_alu_control_signals = NB_FUNCT'(CODE_SLT);
      NB_ALU_OP'(ALU_OP_SUB):        o_alu_control_signals = NB_FUNCT'(CODE_SUB);
      default:                       o_alu_control_signals = NB_FUNCT'(CODE_ADD);
    endcase
  end

  // Muldiv instruction classification and launch conditions
  always_comb begin
    is_rtype  = (i_alu_op_CU == NB_ALU_OP'(ALU_OP_R_TYPE));
    is_mul    = (i_op_r_tipe == NB_FUNCT'(FUNCT_MULT)) ||
                (i_op_r_tipe == NB_FUNCT'(FUNCT_MULTU));
    is_div    = (i_op_r_tipe == NB_FUNCT'(FUNCT_DIV)) ||
                (i_op_r_tipe == NB_FUNCT'(FUNCT_DIVU));
    op_signed = (i_op_r_tipe == NB_FUNCT'(FUNCT_MULT)) ||
                (i_op_r_tipe == NB_FUNCT'(FUNCT_DIV));
    start     = (state_q == ST_IDLE) && i_valid && is_rtype &&
                (is_mul || is_div) && !i_flush;
    mthi_we   = (state_q == ST_IDLE) && i_valid && is_rtype && !i_flush &&
                (i_op_r_tipe == NB_FUNCT'(FUNCT_MTHI));
    mtlo_we   = (state_q == ST_IDLE) && i_valid && is_rtype && !i_flush &&
                (i_op_r_tipe == NB_FUNCT'(FUNCT_MTLO));
    step      = (state_q == ST_RUN) && !i_flush;
    // DONE is deliberately excluded so the pipeline releases the instruction
    o_stall   = start || (state_q == ST_RUN);
  end

  assign o_busy = busy_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

  ex_muldiv_datapath #(
    .NB_DATA(NB_DATA)
  ) u_datapath (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .load_i     (start),
    .step_i     (step),
    .op_div_i   (is_div),
    .op_signed_i(op_signed),
    .rs_i       (i_rs_data),
    .rt_i       (i_rt_data),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo)
  );

  // Sequencer FSM with iteration counter, busy flag and HI/LO registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
            if (is_mul) begin
              state_q <= ST_DONE;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_RUN;
              cnt_q   <= NB_CNT'(NB_DATA);
            end
`else
            state_q <= ST_RUN;
            cnt_q   <= NB_CNT'(NB_DATA);
`endif
          end else if (mthi_we) begin
            hi_q <= i_rs_data;
          end else if (mtlo_we) begin
            lo_q <= i_rs_data;
          end
        end
        ST_RUN: begin
          if (i_flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == NB_CNT'(1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Never re-launches: the finished instruction is still in EX here
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!i_flush) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_muldiv_ctrl.sv
// Bench for ex_alu_muldiv_ctrl: decode sweep, directed and random muldiv
// operations against an arithmetic reference model, MTHI/MTLO, flush and
// asynchronous reset. Results are checked by a monitor popping exp_q.
module tb_ex_alu_muldiv_ctrl;

  localparam int NB_DATA   = 32;
  localparam int NB_FUNCT  = 6;
  localparam int NB_ALU_OP = 4;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_valid;
  logic                 i_flush;
  logic [NB_ALU_OP-1:0] i_alu_op_CU;
  logic [NB_FUNCT-1:0]  i_op_r_tipe;
  logic [NB_DATA-1:0]   i_rs_data;
  logic [NB_DATA-1:0]   i_rt_data;
  logic [NB_FUNCT-1:0]  o_alu_control_signals;
  logic                 o_stall;
  logic                 o_busy;
  logic [NB_DATA-1:0]   o_hi;
  logic [NB_DATA-1:0]   o_lo;

  int total = 0;
  int bad   = 0;
  logic [2*NB_DATA-1:0] exp_q[$];
  bit busy_prev = 1'b0;

  // ---------------- clock / reset block
  always #5 i_clk = ~i_clk;

  ex_alu_muldiv_ctrl #(
    .NB_DATA  (NB_DATA),
    .NB_FUNCT (NB_FUNCT),
    .NB_ALU_OP(NB_ALU_OP)
  ) dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_valid              (i_valid),
    .i_flush              (i_flush),
    .i_alu_op_CU          (i_alu_op_CU),
    .i_op_r_tipe          (i_op_r_tipe),
    .i_rs_data            (i_rs_data),
    .i_rt_data            (i_rt_data),
    .o_alu_control_signals(o_alu_control_signals),
    .o_stall              (o_stall),
    .o_busy               (o_busy),
    .o_hi                 (o_hi),
    .o_lo                 (o_lo)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: {HI, LO} from plain arithmetic
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sp;
    int sa, sb, q, r;
    sa = a;
    sb = b;
    case (f)
      F_MULT: begin
        sp = longint'(sa) * longint'(sb);
        return 64'(sp);
      end
      F_MULTU: return {32'd0, a} * {32'd0, b};
      F_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // ---------------- monitor / scoreboard: a completed op ends busy w/o flush
  always @(posedge i_clk) begin
    #2;
    if (!i_rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !o_busy && !i_flush) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected result: got %h with empty queue", {o_hi, o_lo});
        end else begin
          check("hi/lo result", {o_hi, o_lo}, exp_q.pop_front());
        end
      end
      busy_prev = o_busy;
    end
  end

  // ---------------- driver tasks (called at a negedge)
  task automatic drive_idle();
    i_valid     = 1'b0;
    i_flush     = 1'b0;
    i_alu_op_CU = '0;
    i_op_r_tipe = '0;
    i_rs_data   = '0;
    i_rt_data   = '0;
  endtask

  task automatic run_muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            input int flush_at, input string tag);
    int stalls;
    int exp_stalls;
    bit done;
    logic [31:0] hi0, lo0;
    hi0 = o_hi;
    lo0 = o_lo;
    exp_stalls = NB_DATA + 1;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    if (f == F_MULT || f == F_MULTU) exp_stalls = 1;
`endif
    i_valid     = 1'b1;
    i_alu_op_CU = 4'b0010;
    i_op_r_tipe = f;
    i_rs_data   = a;
    i_rt_data   = b;
    i_flush     = 1'b0;
    if (flush_at < 0) exp_q.push_back(model(f, a, b));
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c == flush_at) i_flush = 1'b1;
      #1;
      if (o_stall) stalls++;
      else done = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      if (i_flush) begin
        i_flush = 1'b0;
        i_valid = 1'b0;
        done    = 1'b1;
        #1;
        check({tag, " stall after flush"}, 64'(o_stall), 64'd0);
        check({tag, " busy after flush"}, 64'(o_busy), 64'd0);
        check({tag, " hi/lo kept on flush"}, {o_hi, o_lo}, {hi0, lo0});
      end
    end
    check({tag, " completion"}, 64'(done), 64'd1);
    if (flush_at < 0) check({tag, " stall cycles"}, 64'(stalls), 64'(exp_stalls));
    drive_idle();
  endtask

  task automatic run_mt(input logic [5:0] f, input logic [31:0] v);
    i_valid     = 1'b1;
    i_alu_op_CU = 4'b0010;
    i_op_r_tipe = f;
    i_rs_data   = v;
    #1;
    check("mt stall", 64'(o_stall), 64'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    drive_idle();
    #1;
    if (f == F_MTHI) check("mthi value", 64'(o_hi), 64'(v));
    else check("mtlo value", 64'(o_lo), 64'(v));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // decode table: ALUOp, funct, expected code
  logic [3:0] dec_op   [11] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1001,
                                4'b1100, 4'b0111, 4'b0010, 4'b0010, 4'b1111};
  logic [5:0] dec_fn   [11] = '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000,
                                6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100101,
                                6'b100000};
  logic [5:0] dec_code [11] = '{6'b100000, 6'b100000, 6'b100100, 6'b100101, 6'b100110,
                                6'b001111, 6'b101010, 6'b100010, 6'b100000, 6'b100101,
                                6'b100000};

  initial begin
    logic [5:0] fsel [4];
    fsel = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    drive_idle();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset hi", 64'(o_hi), 64'd0);
    check("reset lo", 64'(o_lo), 64'd0);
    check("reset stall", 64'(o_stall), 64'd0);
    check("reset busy", 64'(o_busy), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // decode sweep
    for (int k = 0; k < 11; k++) begin
      i_alu_op_CU = dec_op[k];
      i_op_r_tipe = dec_fn[k];
      #1;
      check($sformatf("decode op=%b", dec_op[k]), 64'(o_alu_control_signals), 64'(dec_code[k]));
    end
    for (int k = 0; k < 4; k++) begin
      i_alu_op_CU = 4'b0010;
      i_op_r_tipe = 6'($urandom);
      #1;
      check("decode funct pass", 64'(o_alu_control_signals), 64'(i_op_r_tipe));
    end
    drive_idle();
    @(negedge i_clk);

    // directed arithmetic
    run_muldiv(F_MULT,  32'hFFFF_FFFD, 32'd7,        -1, "mult -3*7");
    run_muldiv(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu max");
    run_muldiv(F_DIV,   32'hFFFF_FFF9, 32'd2,        -1, "div -7/2");
    run_muldiv(F_DIVU,  32'd100,       32'd7,        -1, "divu 100/7");
    run_muldiv(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, "div min/-1");
    run_muldiv(F_DIVU,  32'd5,         32'd0,        -1, "divu 5/0");
    run_muldiv(F_DIV,   32'hFFFF_FFFB, 32'd0,        -1, "div -5/0");

    // MTHI / MTLO, then flushed op leaves them intact
    run_mt(F_MTHI, 32'h0000_1234);
    run_mt(F_MTLO, 32'h0000_5678);
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    run_muldiv(F_DIVU, 32'd99, 32'd4, 10, "flush");
`else
    run_muldiv(F_MULT, 32'd99, 32'd4, 10, "flush");
`endif
    check("hi after flush", 64'(o_hi), 64'h1234);
    check("lo after flush", 64'(o_lo), 64'h5678);

    // asynchronous reset in RUN cycle 5
    i_valid     = 1'b1;
    i_alu_op_CU = 4'b0010;
    i_op_r_tipe = F_DIV;
    i_rs_data   = 32'd77;
    i_rt_data   = 32'd5;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("async reset hi", 64'(o_hi), 64'd0);
    check("async reset lo", 64'(o_lo), 64'd0);
    check("async reset stall", 64'(o_stall), 64'd0);
    check("async reset busy", 64'(o_busy), 64'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive_idle();
    @(negedge i_clk);
    run_muldiv(F_MULT, 32'd2, 32'd3, -1, "mult 2*3 after reset");

    // random operations
    for (int n = 0; n < 24; n++) begin
      logic [5:0] f;
      f = fsel[$urandom_range(0, 3)];
      run_muldiv(f, rand_operand(), rand_operand(), -1, $sformatf("random %0d", n));
    end

    repeat (4) @(negedge i_clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
